invsort_ctrl: RTL and testbench
===============================

Name: invsort_ctrl

Overview:
- Issue controller in front of the 2-stage inverse-sort datapath of the encoder.
- Accepts per-group slot-select vectors (8 quantized indices) from context lookup over a valid/ready handshake and drives the datapath's select and end-token inputs.
- Holds selects at the null index when idle, so the datapath emits all-zero, invalid slots.
- Meters issues against credits of the downstream group FIFO, since the datapath cannot stall; sequences end-of-tile drain and end-token insertion.

Parameters:
- DEPTH, 8: downstream FIFO entries, i.e. initial credits.
- LAT, 2: datapath latency in cycles; drain wait before the end token.
- NULLQ, 14: select index whose lane is tied to zero/invalid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  upstream group valid
- s_ready  out  1  upstream ready
- s_ql[1:8]  in  4 each  slot select indices; 0..12 lane, 13 run, 14..15 illegal
- s_last  in  1  group is last of tile
- d_pop  in  1  downstream FIFO pop pulse; returns one credit
- o_ql[1:8]  out  4 each  selects to datapath
- o_et  out  1  end-token pulse to datapath
- o_credit  out  $clog2(DEPTH+1)  current credits
- o_grp_cnt  out  16  groups issued in current tile
- o_err  out  2  sticky flags: [0] illegal ql, [1] credit overflow

Behaviour:
- Reset values:
  - o_ql all = NULLQ, o_et = 0, o_credit = DEPTH, o_grp_cnt = 0, o_err = 0, state = RUN.
  - Reset mid-drain or mid-token aborts and returns to RUN without emitting o_et.
- Handshake:
  - s_ready = (state==RUN) && credit!=0, decoded from registers only; no combinational path from s_valid.
  - Accept = s_valid && s_ready.
  - s_ql is ignored when no accept occurs.
- Issue timing:
  - On an accept in cycle N, o_ql = s_ql (registered) in cycle N+1 only; otherwise o_ql = NULLQ.
  - Datapath output appears at N+1+LAT.
- Illegal indices:
  - Any s_ql[i] > 13 on accept is driven as NULLQ and sets o_err[0].
  - Index 13 (run) passes unchanged.
- Credits:
  - Each group issue and each end-token issue consumes 1 credit; each d_pop returns 1.
  - Simultaneous consume and pop: credit unchanged.
  - Pop while credit==DEPTH with no consume: credit holds at DEPTH and o_err[1] is set.
  - Credit never underflows, because issue is gated by credit!=0.
- Group counter:
  - o_grp_cnt +1 per accepted group, wrapping at 2^16.
  - Cleared in the cycle o_et is asserted.
- FSM:
  - RUN: accept groups. An accept with s_last moves to DRAIN and loads drain counter = LAT.
  - DRAIN: s_ready = 0. Counter decrements each cycle. At 0, go to ETOK.
  - ETOK: s_ready = 0. When credit!=0, register o_et = 1 for exactly one cycle (with o_ql = NULLQ), consume a credit, and return to RUN. Otherwise wait in ETOK.
- Back-to-back:
  - Groups may be accepted every cycle while credits last.
  - A new tile may be accepted in the cycle after o_et.
- o_err:
  - Cleared only by rst.

Decomposition:
- Shared package:
  - Typedef ql_t (4-bit).
  - Constants QL_RUN=13 and QL_NULL=14.
  - Lane count 14 and slot count 8.
  - Enum ctrl_state_t {RUN, DRAIN, ETOK}.
- One sub-module, invsort_credit: credit counter with consume/return/overflow flag, reused by other FIFO-fed stages.
- FSM and issue registers stay in invsort_ctrl.

Test Plan:
- Reset then idle 10 cycles -> o_ql all 14, o_et = 0, o_credit = 8, s_ready = 1.
- 8 back-to-back groups (s_ql = 1..8), no pops -> 8 accepts; s_ready drops after the 8th; o_credit = 0; o_grp_cnt = 8; each o_ql appears one cycle after its accept.
- Same as above, then one d_pop -> o_credit = 1, s_ready reasserts, next group accepted; pop coinciding with accept leaves o_credit unchanged.
- Group with s_last at cycle N, credits free -> s_ready low N+1..N+3; o_et = 1 at N+4 (LAT=2); o_grp_cnt cleared; credit decremented by 2 in total for group plus token.
- s_ql[3] = 15 and s_ql[5] = 13 on accept -> o_ql[3] = 14, o_ql[5] = 13, o_err = 2'b01 and stays set.
- Two extra d_pop with credit = 8 -> o_credit stays 8, o_err[1] = 1.
- rst asserted while in DRAIN -> no o_et, o_credit = 8, state RUN.

Source files
------------

// File: rtl/invsort_ctrl_pkg.sv
// Shared types and constants for the inverse-sort issue path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package invsort_ctrl_pkg;

   typedef logic [3:0] ql_t;

   localparam ql_t QL_RUN    = 4'd13;  // run token, passed through unchanged
   localparam ql_t QL_NULL   = 4'd14;  // lane tied to zero/invalid
   localparam int  NUM_LANES = 14;     // legal select codes are 0..NUM_LANES-1
   localparam int  NUM_SLOTS = 8;      // selects per group

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      ETOK
   } ctrl_state_t;

   // Codes 0..12 pick a lane and 13 is the run token; anything above is illegal.
   function automatic logic ql_illegal(input ql_t q);
      return q >= ql_t'(NUM_LANES);
   endfunction

endpackage

// File: rtl/invsort_credit.sv
// Credit counter for a downstream FIFO: starts full, consume takes one, ret gives one back.
// Latency: credit updates on the edge after consume/ret; ovf is combinational from the current inputs.
// Backpressure: caller must not consume at zero; a return at full holds the count and raises ovf.
// Ports: clk, rst (sync, active-high), consume, ret, credit (current count), ovf (return at full).
module invsort_credit #(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         consume,
   input  logic                         ret,
   output logic [$clog2(DEPTH+1)-1:0]   credit,
   output logic                         ovf
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] credit_q;
   logic [CW-1:0] credit_d;

   always_comb begin
      credit_d = credit_q;
      ovf      = 1'b0;
      // A simultaneous consume and return cancel out.
      if (consume && !ret) begin
         if (credit_q != '0) begin
            credit_d = credit_q - 1'b1;
         end
      end else if (ret && !consume) begin
         if (credit_q == CW'(DEPTH)) begin
            ovf = 1'b1;
         end else begin
            credit_d = credit_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= CW'(DEPTH);
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit = credit_q;

endmodule

// File: rtl/invsort_ctrl.sv
// Issue controller for the inverse-sort datapath: registers group selects, meters them against
// downstream FIFO credits and sequences the end-of-tile drain and end token.
// Latency: selects appear one cycle after accept; the end token lands LAT+2 cycles after the last group's accept.
// Backpressure: s_ready is a pure register decode (RUN and credit available); the datapath itself never stalls.
// Ports: clk/rst; s_valid/s_ready/s_ql/s_last upstream; d_pop credit return;
//        o_ql/o_et to datapath; o_credit, o_grp_cnt, o_err status.
module invsort_ctrl
   import invsort_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LAT   = 2,
   parameter int NULLQ = QL_NULL
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [3:0]                   s_ql [1:NUM_SLOTS],
   input  logic                         s_last,
   input  logic                         d_pop,
   output logic [3:0]                   o_ql [1:NUM_SLOTS],
   output logic                         o_et,
   output logic [$clog2(DEPTH+1)-1:0]   o_credit,
   output logic [15:0]                  o_grp_cnt,
   output logic [1:0]                   o_err
);

   localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

   ctrl_state_t   state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   ql_t           ql_q [1:NUM_SLOTS];
   ql_t           ql_d [1:NUM_SLOTS];
   logic          et_q, et_d;
   logic [15:0]   grp_q, grp_d;
   logic [1:0]    err_q, err_d;

   logic          accept;
   logic          tok_fire;
   logic          illegal;
   logic          consume;
   logic          ovf;
   logic [$clog2(DEPTH+1)-1:0] credit;

   invsort_credit #(.DEPTH(DEPTH)) u_credit (
      .clk     (clk),
      .rst     (rst),
      .consume (consume),
      .ret     (d_pop),
      .credit  (credit),
      .ovf     (ovf)
   );

   assign s_ready = (state_q == RUN) && (credit != '0);
   assign accept  = s_valid && s_ready;
   assign consume = accept || tok_fire;

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      et_d     = 1'b0;
      grp_d    = grp_q;
      tok_fire = 1'b0;
      illegal  = 1'b0;
      for (int i = 1; i <= NUM_SLOTS; i++) begin
         ql_d[i] = ql_t'(NULLQ);
      end

      // Selects are only live for the single cycle after an accept.
      if (accept) begin
         grp_d = grp_q + 16'd1;
         for (int i = 1; i <= NUM_SLOTS; i++) begin
            if (ql_illegal(s_ql[i])) begin
               illegal = 1'b1;
            end else begin
               ql_d[i] = s_ql[i];
            end
         end
      end

      case (state_q)
         RUN: begin
            if (accept && s_last) begin
               state_d = DRAIN;
               drain_d = DW'(LAT);
            end
         end
         DRAIN: begin
            if (drain_q != '0) begin
               drain_d = drain_q - 1'b1;
            end
            // Leave when the count reaches zero this cycle so that the token
            // registers exactly LAT cycles after the last group's selects.
            if (drain_q <= DW'(1)) begin
               state_d = ETOK;
            end
         end
         ETOK: begin
            if (credit != '0) begin
               et_d     = 1'b1;
               tok_fire = 1'b1;
               grp_d    = '0;
               state_d  = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      err_d = err_q | {ovf, illegal};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         drain_q <= '0;
         et_q    <= 1'b0;
         grp_q   <= '0;
         err_q   <= '0;
         for (int i = 1; i <= NUM_SLOTS; i++) begin
            ql_q[i] <= ql_t'(NULLQ);
         end
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         et_q    <= et_d;
         grp_q   <= grp_d;
         err_q   <= err_d;
         for (int i = 1; i <= NUM_SLOTS; i++) begin
            ql_q[i] <= ql_d[i];
         end
      end
   end

   assign o_ql      = ql_q;
   assign o_et      = et_q;
   assign o_credit  = credit;
   assign o_grp_cnt = grp_q;
   assign o_err     = err_q;

endmodule

// File: tb/tb_invsort_ctrl.sv
// Directed bench for invsort_ctrl with DEPTH=8, LAT=2, NULLQ=14.
module tb_invsort_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [3:0]  s_ql [1:8];
   logic        s_last;
   logic        d_pop;
   logic [3:0]  o_ql [1:8];
   logic        o_et;
   logic [3:0]  o_credit;
   logic [15:0] o_grp_cnt;
   logic [1:0]  o_err;

   int errors = 0;
   int checks = 0;

   invsort_ctrl #(.DEPTH(8), .LAT(2), .NULLQ(14)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_ql      (s_ql),
      .s_last    (s_last),
      .d_pop     (d_pop),
      .o_ql      (o_ql),
      .o_et      (o_et),
      .o_credit  (o_credit),
      .o_grp_cnt (o_grp_cnt),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ql_all(input int v);
      for (int i = 1; i <= 8; i++) s_ql[i] = 4'(v);
   endtask

   task automatic check_ql_null(input string tag);
      for (int i = 1; i <= 8; i++) check($sformatf("%s[%0d]", tag, i), 32'(o_ql[i]), 32'd14);
   endtask

   int et_seen;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; d_pop = 1'b0;
      set_ql_all(0);
      tick; tick;
      rst = 1'b0;
      repeat (10) tick;

      // Idle after reset
      check_ql_null("idle_ql");
      check("idle_et",     32'(o_et), 0);
      check("idle_credit", 32'(o_credit), 8);
      check("idle_ready",  32'(s_ready), 1);
      check("idle_grp",    32'(o_grp_cnt), 0);
      check("idle_err",    32'(o_err), 0);

      // Eight back-to-back groups exhaust the credits
      for (int g = 0; g < 8; g++) begin
         check($sformatf("b2b_ready%0d", g), 32'(s_ready), 1);
         s_valid = 1'b1;
         for (int i = 1; i <= 8; i++) s_ql[i] = 4'((i + g) % 13);
         tick;
         for (int i = 1; i <= 8; i++)
            check($sformatf("b2b_ql%0d[%0d]", g, i), 32'(o_ql[i]), 32'((i + g) % 13));
         check($sformatf("b2b_credit%0d", g), 32'(o_credit), 32'(7 - g));
         check($sformatf("b2b_grp%0d", g), 32'(o_grp_cnt), 32'(g + 1));
      end
      // Still offering an illegal group with no credit: must be ignored
      set_ql_all(15);
      check("nocred_ready", 32'(s_ready), 0);
      tick;
      s_valid = 1'b0;
      check_ql_null("nocred_ql");
      check("nocred_err",    32'(o_err), 0);
      check("nocred_credit", 32'(o_credit), 0);
      check("nocred_grp",    32'(o_grp_cnt), 8);

      // One pop reopens the gate; accept coinciding with a pop keeps credit
      d_pop = 1'b1;
      tick;
      d_pop = 1'b0;
      check("pop_credit", 32'(o_credit), 1);
      check("pop_ready",  32'(s_ready), 1);
      s_valid = 1'b1; d_pop = 1'b1; set_ql_all(5);
      tick;
      s_valid = 1'b0; d_pop = 1'b0;
      check("popacc_credit", 32'(o_credit), 1);
      check("popacc_grp",    32'(o_grp_cnt), 9);
      check("popacc_ql",     32'(o_ql[2]), 5);
      d_pop = 1'b1;
      repeat (7) tick;
      d_pop = 1'b0;
      check("refill_credit", 32'(o_credit), 8);
      check("refill_err",    32'(o_err), 0);

      // Last group of a tile: drain LAT cycles then end token
      s_valid = 1'b1; s_last = 1'b1; set_ql_all(3);
      tick;                                  // cycle N+1
      s_valid = 1'b0; s_last = 1'b0;
      check("last_ready1",  32'(s_ready), 0);
      check("last_et1",     32'(o_et), 0);
      check("last_credit1", 32'(o_credit), 7);
      check("last_grp1",    32'(o_grp_cnt), 10);
      check("last_ql1",     32'(o_ql[1]), 3);
      tick;                                  // N+2
      check("last_ready2", 32'(s_ready), 0);
      check("last_et2",    32'(o_et), 0);
      tick;                                  // N+3
      check("last_ready3", 32'(s_ready), 0);
      check("last_et3",    32'(o_et), 0);
      check_ql_null("last_ql3");
      tick;                                  // N+4
      check("tok_et",     32'(o_et), 1);
      check("tok_grp",    32'(o_grp_cnt), 0);
      check("tok_credit", 32'(o_credit), 6);
      check("tok_ready",  32'(s_ready), 1);
      check_ql_null("tok_ql");
      tick;                                  // N+5
      check("tok_et_off", 32'(o_et), 0);
      d_pop = 1'b1;
      repeat (2) tick;
      d_pop = 1'b0;
      check("tok_refill", 32'(o_credit), 8);

      // Illegal and run indices
      s_valid = 1'b1; set_ql_all(2); s_ql[3] = 4'd15; s_ql[5] = 4'd13;
      tick;
      s_valid = 1'b0;
      check("ill_ql3", 32'(o_ql[3]), 14);
      check("ill_ql5", 32'(o_ql[5]), 13);
      check("ill_ql1", 32'(o_ql[1]), 2);
      check("ill_err", 32'(o_err), 1);
      repeat (3) tick;
      check("ill_sticky", 32'(o_err), 1);
      d_pop = 1'b1;
      tick;
      d_pop = 1'b0;
      check("ill_credit", 32'(o_credit), 8);

      // Pops at full credit
      d_pop = 1'b1;
      repeat (2) tick;
      d_pop = 1'b0;
      check("ovf_credit", 32'(o_credit), 8);
      check("ovf_err",    32'(o_err), 3);

      // Reset while draining aborts the token
      s_valid = 1'b1; s_last = 1'b1; set_ql_all(1);
      tick;
      s_valid = 1'b0; s_last = 1'b0;
      check("rstd_credit_pre", 32'(o_credit), 7);
      check("rstd_ready_pre",  32'(s_ready), 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rstd_credit", 32'(o_credit), 8);
      check("rstd_ready",  32'(s_ready), 1);
      check("rstd_err",    32'(o_err), 0);
      check("rstd_et",     32'(o_et), 0);
      et_seen = 0;
      repeat (6) begin
         tick;
         if (o_et) et_seen++;
      end
      check("rstd_no_et", 32'(et_seen), 0);
      check("rstd_grp",   32'(o_grp_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
